// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: requester-side controller for a byte memory with separate
// write and read ports and a registered read. Commands arrive on a
// valid/ready request channel and read data returns in order on a
// valid/ready response channel.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid may not depend on ready, and the sender holds its payload
// stable while valid is high and ready is low.
//
// Reads are admitted only while credit remains, where credit is the number
// of response FIFO slots not already owned by queued data or by reads still
// in the memory pipe. This guarantees that every read leaving the pipe finds
// a free FIFO slot. Writes use the same gate so that ordering stays simple.
module mem_access_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  busy
);

    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(RSP_DEPTH);
    localparam logic [PW-1:0] LAST_W  = PW'(RSP_DEPTH - 1);

    // Goes high one cycle after reset release; holds off acceptance until then.
    logic                  run_q;
    // One valid bit per read travelling through the memory's read latency.
    logic [RD_LATENCY-1:0] pipe_q;
    logic [RD_LATENCY-1:0] pipe_d;
    logic [CW-1:0]         inflight_q;
    logic [CW-1:0]         inflight_d;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;
    logic [PW-1:0]         wptr_q;
    logic [PW-1:0]         wptr_d;
    logic [PW-1:0]         rptr_q;
    logic [PW-1:0]         rptr_d;
    logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];

    logic [CW:0] used;
    logic        fire;
    logic        rd_fire;
    logic        pipe_exit;
    logic        push;
    logic        pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_W) ? '0 : p + PW'(1);
    endfunction

    // Request acceptance, memory pin drive and FIFO push/pop decisions.
    always_comb begin
        used      = {1'b0, inflight_q} + {1'b0, count_q};
        req_ready = rst_n & run_q & (used < DEPTH_W);
        fire      = req_valid & req_ready;
        rd_fire   = fire & ~req_we;
        pipe_exit = pipe_q[RD_LATENCY-1];
        push      = pipe_exit;
        rsp_valid = (count_q != '0);
        pop       = rsp_valid & rsp_ready;
        rsp_rdata = fifo_q[rptr_q];
        busy      = (inflight_q != '0) | (count_q != '0);

        mem_wr_en   = fire & req_we;
        mem_rd_en   = rd_fire;
        mem_wr_addr = req_addr;
        mem_rd_addr = req_addr;
        mem_wr_data = req_wdata;
    end

    // Next-state for the read pipe, in-flight counter and FIFO bookkeeping.
    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = rd_fire;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        inflight_d = inflight_q;
        if (rd_fire && !pipe_exit) begin
            inflight_d = inflight_q + CW'(1);
        end else if (!rd_fire && pipe_exit) begin
            inflight_d = inflight_q - CW'(1);
        end

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end

        wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = pop  ? ptr_inc(rptr_q) : rptr_q;
    end

    // State registers; reset discards in-flight reads and queued responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            pipe_q     <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            run_q      <= 1'b1;
            pipe_q     <= pipe_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            if (push) begin
                fifo_q[wptr_q] <= mem_rd_data;
            end
        end
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Requester-side controller for the team's single-port-pair byte memory (separate write and read ports, registered read). Accepts read/write commands on a valid/ready request channel and drives the memory's wr_en/wr_addr/wr_data and rd_en/rd_addr pins. Returns read data in order on a valid/ready response channel. Sits between any bus master and the memory, replacing hand-driven enables like those used in bring-up benches.

Parameters:
ADDR_WIDTH, 8, memory address width (256-byte memory)
DATA_WIDTH, 8, data width
RD_LATENCY, 1, cycles from mem_rd_en sampled to mem_rd_data valid (>=1)
RSP_DEPTH, 4, response FIFO entries; also the maximum number of reads in flight plus queued

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  command valid
req_ready  out  1  command accepted when valid&ready
req_we  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  command address
req_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  read data valid
rsp_ready  in  1  consumer accepts rsp_rdata
rsp_rdata  out  DATA_WIDTH  read data, in command order
mem_wr_en  out  1  memory write enable
mem_wr_addr  out  ADDR_WIDTH  memory write address
mem_wr_data  out  DATA_WIDTH  memory write data
mem_rd_en  out  1  memory read enable
mem_rd_addr  out  ADDR_WIDTH  memory read address
mem_rd_data  in  DATA_WIDTH  memory read data
busy  out  1  reads in flight or responses queued

Behaviour:
- Reset (async assert, sync release): in-flight pipe cleared, FIFO empty, counters 0; req_ready=0, rsp_valid=0, rsp_rdata=0, mem_wr_en=0, mem_rd_en=0, busy=0.
- credit = RSP_DEPTH - (inflight + fifo_count); req_ready = rst_n released && credit>0. Writes obey the same gate to keep ordering simple.
- Accept: fire = req_valid & req_ready, same cycle. mem_wr_en = fire & req_we; mem_rd_en = fire & ~req_we. Combinational from the request. mem_wr_addr/mem_rd_addr = req_addr and mem_wr_data = req_wdata, passed through unconditionally.
- Writes produce no response and complete at the accepting edge.
- Reads: valid bit enters an RD_LATENCY-deep shift pipe at the accepting edge. When the bit exits, mem_rd_data is pushed into the FIFO at that edge.
- Latency (RD_LATENCY=1): read accepted cycle N → rsp_valid asserted cycle N+2 at earliest. Throughput: 1 read/cycle while rsp_ready=1.
- FIFO: RSP_DEPTH entries, ptr wrap modulo depth, registered rsp_rdata = head. Pop on rsp_valid & rsp_ready. Push and pop in the same cycle leaves count unchanged.
- Credit accounting counts in-flight reads, so a pipe push can never overflow the FIFO. Full with rsp_ready=0 → req_ready=0 until a pop.
- Read-after-write to the same address in consecutive accepted commands returns the new data, because the memory commits the write at the accepting edge.
- busy = (inflight != 0) | (fifo_count != 0).
- rsp_valid held and rsp_rdata stable while rsp_ready=0.
- Reset mid-operation: in-flight reads and queued responses are discarded. No spurious rsp_valid after release. Memory enables drop immediately on rst_n low.

Test Plan:
- Reset: rst_n=0 with req_valid=1 → req_ready=0, mem_wr_en=0, mem_rd_en=0, rsp_valid=0. Release → req_ready=1 on the next cycle.
- Write 0x55@0x00 then 0xAA@0x01, followed by read 0x00 and read 0x01 back-to-back, rsp_ready=1 → rsp_rdata 0x55 then 0xAA on consecutive cycles. First response 2 cycles after the read is accepted; mem_rd_en is never asserted on write cycles.
- Back-pressure: rsp_ready=0, issue 6 reads of 0x10..0x15 (preloaded 0xA0..0xA5) → exactly 4 accepted, then req_ready=0 and busy=1. Raise rsp_ready → 0xA0..0xA3 in order, req_ready returns.
- Read-after-write: write 0x3C@0x20, next cycle read 0x20 → response 0x3C.
- Simultaneous push/pop: continuous reads with rsp_ready=1 → FIFO count stays ≤1 and a response arrives every cycle.
- Reset mid-flight: 3 reads queued, rst_n low for 1 cycle → rsp_valid=0, busy=0 afterwards. A new read of 0x01 returns 0xAA only.
